// File: rtl/clk_en_gen_pkg.sv
// Shared constants and helpers for the clk_en_gen clock-enable generator.
package clk_en_gen_pkg;

   localparam int unsigned DIV_MIN      = 1;
   localparam int unsigned NCH_DEF      = 2;
   localparam int unsigned CNT_W_DEF    = 16;
   localparam int unsigned DIV_INIT_DEF = 2;

   // Number of high cycles of the square wave for a period of d cycles.
   function automatic int unsigned ceil_half(input int unsigned d);
      return (d + 32'd1) >> 1;
   endfunction

   // Width of the channel-select field; never narrower than one bit.
   function automatic int unsigned sel_w(input int unsigned n);
      return (n <= 32'd1) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// Divisor write port, sync input and per-channel enable outputs of clk_en_gen.
interface clk_en_gen_if #(
   parameter int unsigned NCH   = clk_en_gen_pkg::NCH_DEF,
   parameter int unsigned CNT_W = clk_en_gen_pkg::CNT_W_DEF
);
   localparam int unsigned SEL_W = clk_en_gen_pkg::sel_w(NCH);

   logic              div_load;
   logic [SEL_W-1:0]  div_ch;
   logic [CNT_W-1:0]  div_val;
   logic              div_ack;
   logic              sync;
   logic [NCH-1:0]    tick;
   logic [NCH-1:0]    sq;

   modport master (
      output div_load, div_ch, div_val, sync,
      input  div_ack, tick, sq
   );

   modport slave (
      input  div_load, div_ch, div_val, sync,
      output div_ack, tick, sq
   );
endinterface

// File: rtl/clk_en_gen_ch.sv
// One clock-enable channel: period counter, live/pending divisor, tick strobe and
// optional square wave (built only when CLK_EN_GEN_SQ_EN is defined).
module clk_en_gen_ch
   import clk_en_gen_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] val,
   input  logic             sync,
   output logic             tick,
   output logic             sq
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(DIV_MIN);

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] div_cur, div_cur_nxt;
   logic [CNT_W-1:0] div_pend, div_pend_nxt;
   logic             pend, pend_nxt;
   logic             tick_nxt;
   logic [CNT_W-1:0] val_cl_c;
   logic             wrap_c;

   assign val_cl_c = (val < ONE) ? ONE : val;
   assign wrap_c   = (cnt == (div_cur - ONE));

   // sync overrides the wrap; a write arriving on a wrap edge waits for the next boundary
   always_comb begin
      cnt_nxt      = cnt + ONE;
      div_cur_nxt  = div_cur;
      div_pend_nxt = div_pend;
      pend_nxt     = pend;
      tick_nxt     = 1'b0;
      if (sync) begin
         cnt_nxt  = '0;
         pend_nxt = 1'b0;
         if (load) begin
            div_cur_nxt = val_cl_c;
         end else if (pend) begin
            div_cur_nxt = div_pend;
         end
      end else begin
         if (wrap_c) begin
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
            if (pend) begin
               div_cur_nxt = div_pend;
               pend_nxt    = 1'b0;
            end
         end
         if (load) begin
            div_pend_nxt = val_cl_c;
            pend_nxt     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         div_cur  <= DIV_RST;
         div_pend <= DIV_RST;
         pend     <= 1'b0;
         tick     <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         div_cur  <= div_cur_nxt;
         div_pend <= div_pend_nxt;
         pend     <= pend_nxt;
         tick     <= tick_nxt;
      end
   end

`ifdef CLK_EN_GEN_SQ_EN
   logic sq_nxt;

   // High for the first ceil(D/2) counts of each period, using the divisor in force next cycle
   always_comb begin
      sq_nxt = ({1'b0, cnt_nxt} < (CNT_W+1)'(ceil_half(32'(div_cur_nxt))));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sq <= 1'b0;
      end else begin
         sq <= sq_nxt;
      end
   end
`else
   assign sq = 1'b0;
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: write decode, ack register and NCH channels.
// Square-wave outputs are built only when CLK_EN_GEN_SQ_EN is defined.
module clk_en_gen
   import clk_en_gen_pkg::*;
#(
   parameter int unsigned NCH      = NCH_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   clk_en_gen_if.slave  bus
);

   localparam int unsigned SEL_W   = sel_w(NCH);
   localparam bit          CH_FULL = ((32'd1 << SEL_W) == NCH);

   logic           ch_ok_c;
   logic           ack_nxt;
   logic [NCH-1:0] load_c;

   // When the select field exactly covers NCH every encoding is a real channel
   generate
      if (CH_FULL) begin : g_sel_full
         assign ch_ok_c = 1'b1;
      end else begin : g_sel_part
         assign ch_ok_c = (32'(bus.div_ch) < NCH);
      end
   endgenerate

   always_comb begin
      load_c  = '0;
      ack_nxt = bus.div_load && ch_ok_c;
      for (int unsigned i = 0; i < NCH; i++) begin
         load_c[i] = ack_nxt && (bus.div_ch == SEL_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.div_ack <= 1'b0;
      end else begin
         bus.div_ack <= ack_nxt;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clk_en_gen_ch #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_INIT)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .load (load_c[i]),
         .val  (bus.div_val),
         .sync (bus.sync),
         .tick (bus.tick[i]),
         .sq   (bus.sq[i])
      );
   end

endmodule
